vx_tcu_idp_acc: RTL and testbench
=================================

VX_TCU_IDP_ACC -- requirements
Module: VX_tcu_idp_acc

Interface
REQ-001 SHALL have parameter N, default 2: number of 32-bit packed words per operand row/column.
REQ-002 SHALL have parameter MAX_PASSES, default 4: maximum beats per accumulation sequence.
REQ-003 SHALL have parameter SAT, default 1: 1 saturates the result to int32; 0 wraps modulo 2^32.
REQ-004 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: the input beat is valid.
REQ-007 SHALL have port in_ready, output, 1: the block accepts the input beat.
REQ-008 SHALL have ports in_first and in_last, input, 1 each: the beat opens or closes a sequence.
REQ-009 SHALL have port fmt_s, input, 4: operand format, one of the shared-package integer formats I8, U8, I4 or U4.
REQ-010 SHALL have ports a_row and b_col, input, N x 32: packed operands, 4 x 8-bit or 8 x 4-bit elements per word, element 0 in the LSBs.
REQ-011 SHALL have port vld_mask, input, N: word enables; masked words contribute 0.
REQ-012 SHALL have port c_val, input, 32: signed int32 addend, used on the first beat only.
REQ-013 SHALL have port out_valid, input/output direction output, 1: the result is valid.
REQ-014 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-015 SHALL have port d_val, output, 32: the int32 result.
REQ-016 SHALL have port overflow, output, 1: the result exceeded the int32 range; valid with out_valid.
REQ-017 SHALL have port seq_err, output, 1: one-cycle pulse on a sequencing violation.

Function
REQ-018 SHALL define stall = out_valid & ~out_ready, and SHALL drive in_ready = ~stall; all pipeline registers SHALL hold while stall is asserted.
REQ-019 SHALL accept a beat when in_valid & in_ready.
REQ-020 Stage 1 SHALL compute psum, the sum of all element products over unmasked words:
- signed or unsigned per fmt_s;
- 40-bit signed (ACC_W = 40);
- registered together with first, last and c_val.
REQ-021 Unsupported fmt_s SHALL yield psum = 0 and SHALL pulse seq_err.
REQ-022 Stage 2 SHALL compute acc_next as follows:
- first beat: acc_next = sext(c_val) + psum;
- otherwise: acc_next = acc + psum.
- The 40-bit add SHALL wrap (no internal overflow is possible for MAX_PASSES <= 64).
REQ-023 SHALL increment a pass counter per accepted beat and reset it to 1 on a first beat.
REQ-024 On a last beat, stage 2 SHALL set out_valid, and SHALL load d_val and overflow:
- SAT=1: d_val = clamp(acc_next, 0x80000000, 0x7FFFFFFF);
- SAT=0: d_val = acc_next[31:0];
- overflow = (acc_next is outside the int32 range).
REQ-025 Latency: a last beat accepted at cycle t SHALL produce out_valid at t+2 when there is no stall.
REQ-026 out_valid SHALL clear on out_valid & out_ready unless a new last beat completes in the same cycle, in which case the new result SHALL be loaded.
REQ-027 in_first while a sequence is open SHALL restart the accumulator from c_val and SHALL pulse seq_err.
REQ-028 A non-first beat with no open sequence SHALL be treated as first, using c_val, and SHALL pulse seq_err.
REQ-029 A beat that reaches MAX_PASSES without in_last SHALL be treated as last and SHALL pulse seq_err.
REQ-030 in_first & in_last on the same beat SHALL form a single-pass sequence.
REQ-031 Non-accepted cycles SHALL not change acc, the pass counter or the sequence-open flag.

Reset
REQ-032 Reset SHALL asynchronously clear:
- out_valid, overflow and seq_err to 0;
- d_val to 0;
- acc to 0 and the pass counter to 0;
- the sequence-open flag and the stage-1 valid.
REQ-033 in_ready SHALL be 1 during and immediately after reset.
REQ-034 A reset asserted mid-sequence SHALL discard partial state; no output SHALL appear for that sequence.

Structure
REQ-035 The format codes (I8, U8, I4, U4), ACC_W and a format-to-signedness/element-width function SHALL live in VX_tcu_pkg.
REQ-036 The per-word element multiply-reduce SHALL be a sub-module VX_tcu_idp_word, instantiated N times.
REQ-037 The reduction tree and accumulator/control logic SHALL remain in VX_tcu_idp_acc.

Verification
REQ-038 Single pass, I8, N=2: a_row = {0, 0x01020304}, b_col = {0, 0x01010101}, c_val = 5, first = last = 1 -> d_val = 15, overflow = 0, out_valid 2 cycles after accept.
REQ-039 Three passes, each psum = 10, c_val = 1 -> one output, d_val = 31, no output for the intermediate beats.
REQ-040 I8, all elements 0x80 in both words, c_val = 0x7FFFFFF0, SAT=1 -> d_val = 0x7FFFFFFF, overflow = 1; with SAT=0 -> d_val = 0x8001FFF0.
REQ-041 Backpressure: out_ready = 0 for 3 cycles with a second sequence pending -> in_ready = 0 while stalled, d_val held stable, second result delivered the cycle after release.
REQ-042 Sequencing: in_first twice without last -> seq_err pulse and the result uses only the second c_val; MAX_PASSES+1 beats without last -> forced output after beat MAX_PASSES plus seq_err.
REQ-043 Reset asserted between beat 1 and beat 2 -> no output, all outputs 0; a next single-pass sequence with c_val = 7 and zero operands -> d_val = 7.

Source files
------------

// File: rtl/vx_tcu_pkg.sv
// Shared tensor-core definitions: integer operand formats, accumulator width
// and the format decode used by the integer dot-product datapath.
package vx_tcu_pkg;

  localparam int unsigned ACC_W = 40;

  typedef enum logic [3:0] {
    I8 = 4'd1,
    U8 = 4'd2,
    I4 = 4'd3,
    U4 = 4'd4
  } fmt_e;

  typedef struct packed {
    logic supported;
    logic is_signed;
    logic is_4bit;    // element width: 1 -> 4-bit, 0 -> 8-bit
  } fmt_info_t;

  function automatic fmt_info_t fmt_decode(input logic [3:0] fmt);
    fmt_info_t info;
    info = '0;
    case (fmt)
      I8:      info = '{supported: 1'b1, is_signed: 1'b1, is_4bit: 1'b0};
      U8:      info = '{supported: 1'b1, is_signed: 1'b0, is_4bit: 1'b0};
      I4:      info = '{supported: 1'b1, is_signed: 1'b1, is_4bit: 1'b1};
      U4:      info = '{supported: 1'b1, is_signed: 1'b0, is_4bit: 1'b1};
      default: info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/vx_tcu_idp_word.sv
// Multiply-reduce of one packed 32-bit word pair: 4 x 8-bit or 8 x 4-bit
// element products summed into a sign-extended accumulator-width value.
module vx_tcu_idp_word
  import vx_tcu_pkg::*;
(
  input  logic [31:0]             a_i,
  input  logic [31:0]             b_i,
  input  logic                    en_i,
  input  logic                    is_signed_i,
  input  logic                    is_4bit_i,
  output logic signed [ACC_W-1:0] sum_o
);

  // One extra bit per element so unsigned values stay positive in signed math.
  function automatic logic signed [17:0] mul8(input logic [7:0] a, input logic [7:0] b,
                                              input logic sgn);
    logic signed [8:0] ea;
    logic signed [8:0] eb;
    ea = {sgn & a[7], a};
    eb = {sgn & b[7], b};
    return ea * eb;
  endfunction

  function automatic logic signed [9:0] mul4(input logic [3:0] a, input logic [3:0] b,
                                             input logic sgn);
    logic signed [4:0] ea;
    logic signed [4:0] eb;
    ea = {sgn & a[3], a};
    eb = {sgn & b[3], b};
    return ea * eb;
  endfunction

  logic signed [ACC_W-1:0] sum8;
  logic signed [ACC_W-1:0] sum4;

  always_comb begin
    logic signed [17:0] p8;
    sum8 = '0;
    for (int i = 0; i < 4; i++) begin
      p8   = mul8(a_i[8*i +: 8], b_i[8*i +: 8], is_signed_i);
      sum8 = sum8 + {{(ACC_W-18){p8[17]}}, p8};
    end
  end

  always_comb begin
    logic signed [9:0] p4;
    sum4 = '0;
    for (int i = 0; i < 8; i++) begin
      p4   = mul4(a_i[4*i +: 4], b_i[4*i +: 4], is_signed_i);
      sum4 = sum4 + {{(ACC_W-10){p4[9]}}, p4};
    end
  end

  assign sum_o = !en_i ? '0 : (is_4bit_i ? sum4 : sum8);

endmodule

// File: rtl/vx_tcu_idp_acc.sv
// Two-stage integer dot-product accumulator: stage 1 reduces N word products
// into a partial sum, stage 2 accumulates across beats and emits an int32 result.
module vx_tcu_idp_acc
  import vx_tcu_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned MAX_PASSES = 4,
  parameter bit          SAT        = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [3:0]          fmt_s,
  input  logic [N-1:0][31:0]  a_row,
  input  logic [N-1:0][31:0]  b_col,
  input  logic [N-1:0]        vld_mask,
  input  logic [31:0]         c_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         d_val,
  output logic                overflow,
  output logic                seq_err
);

  localparam int unsigned PassW = $clog2(MAX_PASSES + 1);

  logic stall;
  logic accept;

  // Stage 1: format decode and product reduction
  fmt_info_t               fmt;
  logic signed [ACC_W-1:0] word_sum [N];
  logic signed [ACC_W-1:0] psum;

  assign fmt = fmt_decode(fmt_s);

  for (genvar w = 0; w < N; w++) begin : g_word
    vx_tcu_idp_word u_word (
      .a_i         (a_row[w]),
      .b_i         (b_col[w]),
      .en_i        (vld_mask[w] & fmt.supported),
      .is_signed_i (fmt.is_signed),
      .is_4bit_i   (fmt.is_4bit),
      .sum_o       (word_sum[w])
    );
  end

  always_comb begin
    psum = '0;
    for (int w = 0; w < N; w++) begin
      psum = psum + word_sum[w];
    end
  end

  logic                    s1_valid_q;
  logic                    s1_first_q;
  logic                    s1_last_q;
  logic                    s1_fmt_err_q;
  logic [31:0]             s1_c_q;
  logic signed [ACC_W-1:0] s1_psum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_fmt_err_q <= 1'b0;
      s1_c_q       <= '0;
      s1_psum_q    <= '0;
    end else if (!stall) begin
      s1_valid_q   <= accept;
      s1_first_q   <= in_first;
      s1_last_q    <= in_last;
      s1_fmt_err_q <= ~fmt.supported;
      s1_c_q       <= c_val;
      s1_psum_q    <= psum;
    end
  end

  // Stage 2: accumulation and sequencing
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PassW-1:0]        pass_q, pass_d;
  logic                    open_q, open_d;
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             d_val_q, d_val_d;
  logic                    ovf_q, ovf_d;
  logic                    seq_err_q, seq_err_d;

  logic                    eff_first;
  logic                    force_last;
  logic                    eff_last;
  logic signed [ACC_W-1:0] c_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic [PassW-1:0]        pass_next;
  logic                    acc_ovf;

  assign stall  = out_valid_q & ~out_ready;
  assign accept = in_valid & in_ready;

  // A beat with no open sequence always restarts from its own c_val.
  assign eff_first  = s1_first_q | ~open_q;
  assign c_ext      = {{(ACC_W-32){s1_c_q[31]}}, s1_c_q};
  assign acc_next   = (eff_first ? c_ext : acc_q) + s1_psum_q;
  assign pass_next  = eff_first ? PassW'(1) : pass_q + PassW'(1);
  assign force_last = ~s1_last_q & (pass_next >= PassW'(MAX_PASSES));
  assign eff_last   = s1_last_q | force_last;
  assign acc_ovf    = (acc_next[ACC_W-1:31] != '0) && (acc_next[ACC_W-1:31] != '1);

  always_comb begin
    acc_d       = acc_q;
    pass_d      = pass_q;
    open_d      = open_q;
    out_valid_d = out_valid_q;
    d_val_d     = d_val_q;
    ovf_d       = ovf_q;
    seq_err_d   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (s1_valid_q && !stall) begin
      acc_d     = acc_next;
      pass_d    = pass_next;
      open_d    = ~eff_last;
      seq_err_d = s1_fmt_err_q | (s1_first_q & open_q) | (~s1_first_q & ~open_q) | force_last;
      if (eff_last) begin
        out_valid_d = 1'b1;
        ovf_d       = acc_ovf;
        if (SAT && acc_ovf) begin
          d_val_d = acc_next[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
          d_val_d = acc_next[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      pass_q      <= '0;
      open_q      <= 1'b0;
      out_valid_q <= 1'b0;
      d_val_q     <= '0;
      ovf_q       <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      pass_q      <= pass_d;
      open_q      <= open_d;
      out_valid_q <= out_valid_d;
      d_val_q     <= d_val_d;
      ovf_q       <= ovf_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign d_val     = d_val_q;
  assign overflow  = ovf_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_vx_tcu_idp_acc.sv
// Directed bench for vx_tcu_idp_acc: a saturating and a wrapping instance share
// the same stimulus; expected values are hand-computed constants.
module tb_vx_tcu_idp_acc;
  import vx_tcu_pkg::*;

  localparam int unsigned N = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_first;
  logic               in_last;
  logic [3:0]         fmt_s;
  logic [N-1:0][31:0] a_row;
  logic [N-1:0][31:0] b_col;
  logic [N-1:0]       vld_mask;
  logic [31:0]        c_val;
  logic               out_ready;

  logic               in_ready, out_valid, overflow, seq_err;
  logic [31:0]        d_val;
  logic               w_in_ready, w_out_valid, w_overflow, w_seq_err;
  logic [31:0]        w_d_val;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] A1 = 64'h0000_0000_0102_0304;
  localparam logic [63:0] B1 = 64'h0000_0000_0101_0101;

  always #5 clk = ~clk;

  vx_tcu_idp_acc #(.N(N), .MAX_PASSES(4), .SAT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .fmt_s(fmt_s), .a_row(a_row), .b_col(b_col),
    .vld_mask(vld_mask), .c_val(c_val), .out_valid(out_valid), .out_ready(out_ready),
    .d_val(d_val), .overflow(overflow), .seq_err(seq_err)
  );

  vx_tcu_idp_acc #(.N(N), .MAX_PASSES(4), .SAT(1'b0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_first(in_first), .in_last(in_last), .fmt_s(fmt_s), .a_row(a_row), .b_col(b_col),
    .vld_mask(vld_mask), .c_val(c_val), .out_valid(w_out_valid), .out_ready(out_ready),
    .d_val(w_d_val), .overflow(w_overflow), .seq_err(w_seq_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one clock edge.
  task automatic beat(input logic f, input logic l, input logic [3:0] fm, input logic [63:0] a,
                      input logic [63:0] b, input logic [1:0] m, input logic [31:0] c);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    fmt_s    = fm;
    a_row    = a;
    b_col    = b;
    vld_mask = m;
    c_val    = c;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; fmt_s = I8;
    a_row = '0; b_col = '0; vld_mask = 2'b11; c_val = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d_val", d_val, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single pass: 1+2+3+4 + 5
    beat(1'b1, 1'b1, I8, A1, B1, 2'b11, 32'd5);
    chk("sp_not_yet_valid", 32'(out_valid), 32'd0);
    step();
    chk("sp_valid", 32'(out_valid), 32'd1);
    chk("sp_d_val", d_val, 32'd15);
    chk("sp_overflow", 32'(overflow), 32'd0);
    chk("sp_seq_err", 32'(seq_err), 32'd0);
    chk("sp_wrap_valid", 32'(w_out_valid), 32'd1);
    chk("sp_wrap_d_val", w_d_val, 32'd15);
    step();
    chk("sp_drained", 32'(out_valid), 32'd0);

    // Three passes of psum 10 with c=1
    beat(1'b1, 1'b0, I8, A1, B1, 2'b11, 32'd1);
    chk("mp_no_out_1", 32'(out_valid), 32'd0);
    beat(1'b0, 1'b0, I8, A1, B1, 2'b11, 32'd900);
    chk("mp_no_out_2", 32'(out_valid), 32'd0);
    beat(1'b0, 1'b1, I8, A1, B1, 2'b11, 32'd900);
    chk("mp_no_out_3", 32'(out_valid), 32'd0);
    step();
    chk("mp_valid", 32'(out_valid), 32'd1);
    chk("mp_d_val", d_val, 32'd31);
    chk("mp_seq_err", 32'(seq_err), 32'd0);
    step();

    // Positive overflow: 8 x (-128*-128) = 0x20000 on top of 0x7FFFFFF0
    beat(1'b1, 1'b1, I8, {2{32'h8080_8080}}, {2{32'h8080_8080}}, 2'b11, 32'h7FFF_FFF0);
    step();
    chk("ovf_sat_d_val", d_val, 32'h7FFF_FFFF);
    chk("ovf_sat_flag", 32'(overflow), 32'd1);
    chk("ovf_wrap_d_val", w_d_val, 32'h8001_FFF0);
    chk("ovf_wrap_flag", 32'(w_overflow), 32'd1);
    step();

    // Negative overflow: 8 x (-128*127) = -130048 below 0x80000000
    beat(1'b1, 1'b1, I8, {2{32'h8080_8080}}, {2{32'h7F7F_7F7F}}, 2'b11, 32'h8000_0000);
    step();
    chk("neg_sat_d_val", d_val, 32'h8000_0000);
    chk("neg_wrap_d_val", w_d_val, 32'h7FFE_0400);
    chk("neg_ovf_flag", 32'(overflow), 32'd1);
    step();

    // Formats and masking
    beat(1'b1, 1'b1, U8, 64'h0000_0000_FF00_0000, 64'h0000_0000_0200_0000, 2'b11, 32'd0);
    step();
    chk("u8_d_val", d_val, 32'd510);
    step();
    beat(1'b1, 1'b1, I8, 64'h0000_0000_FF00_0000, 64'h0000_0000_0200_0000, 2'b11, 32'd0);
    step();
    chk("i8_neg_d_val", d_val, 32'hFFFF_FFFE);
    step();
    beat(1'b1, 1'b1, I4, 64'h0000_0000_0000_000F, 64'h0000_0000_0000_0003, 2'b11, 32'd0);
    step();
    chk("i4_d_val", d_val, 32'hFFFF_FFFD);
    step();
    beat(1'b1, 1'b1, U4, 64'h0000_0000_0000_000F, 64'h0000_0000_0000_0003, 2'b11, 32'd0);
    step();
    chk("u4_d_val", d_val, 32'd45);
    step();
    beat(1'b1, 1'b1, I8, 64'h0101_0101_0102_0304, 64'h0101_0101_0101_0101, 2'b01, 32'd0);
    step();
    chk("mask_d_val", d_val, 32'd10);
    step();
    beat(1'b1, 1'b1, 4'd0, A1, B1, 2'b11, 32'd3);
    step();
    chk("badfmt_d_val", d_val, 32'd3);
    chk("badfmt_seq_err", 32'(seq_err), 32'd1);
    chk("badfmt_wrap_seq_err", 32'(w_seq_err), 32'd1);
    step();
    chk("badfmt_pulse_end", 32'(seq_err), 32'd0);

    // Backpressure: result A held while B waits in the pipe
    out_ready = 1'b0;
    beat(1'b1, 1'b1, I8, A1, B1, 2'b11, 32'd100);
    beat(1'b1, 1'b1, I8, A1, B1, 2'b11, 32'd200);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_d_val_0", d_val, 32'd110);
    chk("bp_in_ready_0", 32'(in_ready), 32'd0);
    step();
    chk("bp_d_val_1", d_val, 32'd110);
    chk("bp_in_ready_1", 32'(in_ready), 32'd0);
    step();
    chk("bp_d_val_2", d_val, 32'd110);
    chk("bp_in_ready_2", 32'(w_in_ready), 32'd0);
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_d_val", d_val, 32'd210);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Restart: second in_first wins, seq_err when it reaches stage 2
    beat(1'b1, 1'b0, I8, A1, B1, 2'b11, 32'd1000);
    chk("rs_err_0", 32'(seq_err), 32'd0);
    beat(1'b1, 1'b0, I8, A1, B1, 2'b11, 32'd2000);
    chk("rs_err_1", 32'(seq_err), 32'd0);
    beat(1'b0, 1'b1, I8, A1, B1, 2'b11, 32'd0);
    chk("rs_err_pulse", 32'(seq_err), 32'd1);
    chk("rs_no_out", 32'(out_valid), 32'd0);
    step();
    chk("rs_err_clear", 32'(seq_err), 32'd0);
    chk("rs_valid", 32'(out_valid), 32'd1);
    chk("rs_d_val", d_val, 32'd2020);
    step();

    // MAX_PASSES+1 beats without last
    beat(1'b1, 1'b0, I8, A1, B1, 2'b11, 32'd0);
    beat(1'b0, 1'b0, I8, A1, B1, 2'b11, 32'd0);
    beat(1'b0, 1'b0, I8, A1, B1, 2'b11, 32'd0);
    beat(1'b0, 1'b0, I8, A1, B1, 2'b11, 32'd0);
    chk("mx_no_out", 32'(out_valid), 32'd0);
    chk("mx_no_err", 32'(seq_err), 32'd0);
    beat(1'b0, 1'b0, I8, A1, B1, 2'b11, 32'd0);
    chk("mx_forced_valid", 32'(out_valid), 32'd1);
    chk("mx_forced_d_val", d_val, 32'd40);
    chk("mx_forced_err", 32'(seq_err), 32'd1);
    step();
    chk("mx_consumed", 32'(out_valid), 32'd0);
    chk("mx_orphan_err", 32'(seq_err), 32'd1);
    beat(1'b0, 1'b1, I8, A1, B1, 2'b00, 32'd500);
    step();
    chk("mx_tail_d_val", d_val, 32'd10);
    chk("mx_tail_err", 32'(seq_err), 32'd0);
    step();

    // Reset mid-sequence discards partial state
    beat(1'b1, 1'b0, I8, A1, B1, 2'b11, 32'd50);
    reset = 1'b1;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_d_val", d_val, 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    reset = 1'b0;
    step();
    chk("mr_quiet_0", 32'(out_valid), 32'd0);
    step();
    chk("mr_quiet_1", 32'(out_valid), 32'd0);
    beat(1'b1, 1'b1, I8, 64'd0, 64'd0, 2'b11, 32'd7);
    step();
    chk("mr_next_valid", 32'(out_valid), 32'd1);
    chk("mr_next_d_val", d_val, 32'd7);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
